// File: rtl/fifo_pkg.sv
// Shared definitions for the byte/word FIFO family (packing and splitting variants).
package fifo_pkg;

  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned WORD_W        = 16;
  localparam int unsigned DEPTH_DEFAULT = 4;

  // Which byte of the word at the read pointer is presented next.
  typedef enum logic {
    HALF_FIRST  = 1'b0,
    HALF_SECOND = 1'b1
  } half_t;

  // The high byte goes out second in LSB-first order, first in MSB-first order.
  function automatic logic [BYTE_W-1:0] pick_byte(
    input logic [WORD_W-1:0] word,
    input half_t             sel,
    input logic              lsb_first
  );
    if ((sel == HALF_SECOND) == lsb_first)
      return word[WORD_W-1 -: BYTE_W];
    else
      return word[BYTE_W-1:0];
  endfunction

endpackage

// File: rtl/fifo_split_mem.sv
// DEPTH x WORD_W register file: synchronous write, asynchronous read, contents not reset.
module fifo_split_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned AW    = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_split.sv
// Word-in, byte-out FIFO: buffers 16-bit words and emits them as two bytes each.
module fifo_split
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH     = DEPTH_DEFAULT,
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] data_in,
  input  logic        input_valid,
  output logic        input_enable,
  output logic [7:0]  data_out,
  output logic        output_valid,
  input  logic        output_enable
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [AW-1:0]     wr_ptr, wr_ptr_nxt;
  logic [AW-1:0]     rd_ptr, rd_ptr_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  half_t             half, half_nxt;
  logic              wr_fire, rd_fire, pop;
  logic [WORD_W-1:0] rd_word;

  fifo_split_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_fire),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (rd_word)
  );

  // Both handshake flags come from cnt only, so a pop at full frees the slot next cycle.
  assign input_enable = (cnt < CW'(DEPTH));
  assign output_valid = (cnt != '0);
  assign data_out     = output_valid ? pick_byte(rd_word, half, LSB_FIRST != 0) : '0;

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    cnt_nxt    = cnt;
    half_nxt   = half;
    wr_fire    = input_valid && input_enable;
    rd_fire    = output_valid && output_enable;
    pop        = rd_fire && (half == HALF_SECOND);

    if (wr_fire) wr_ptr_nxt = wr_ptr + AW'(1);

    if (rd_fire) begin
      if (half == HALF_FIRST) begin
        half_nxt = HALF_SECOND;
      end else begin
        half_nxt   = HALF_FIRST;
        rd_ptr_nxt = rd_ptr + AW'(1);
      end
    end

    unique case ({wr_fire, pop})
      2'b10:   cnt_nxt = cnt + CW'(1);
      2'b01:   cnt_nxt = cnt - CW'(1);
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      half   <= HALF_FIRST;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      cnt    <= cnt_nxt;
      half   <= half_nxt;
    end
  end

endmodule

// File: doc/fifo_split.md
FIFO_SPLIT -- requirements
Module: fifo_split

Interface
REQ-001 The block SHALL have the parameter DEPTH, default 4, meaning the number of 16-bit word slots (power of two, >= 2).
REQ-002 The block SHALL have the parameter LSB_FIRST, default 1, meaning that 1 emits the low byte of each word first and 0 emits the high byte first.
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have the port rstn, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have the port data_in, input, 16 bits: the word offered by the upstream writer.
REQ-006 The block SHALL have the port input_valid, input, 1 bit: the writer asserts that data_in is valid.
REQ-007 The block SHALL have the port input_enable, output, 1 bit: the block can accept a word this cycle.
REQ-008 The block SHALL have the port data_out, output, 8 bits: the byte presented to the downstream reader.
REQ-009 The block SHALL have the port output_valid, output, 1 bit: data_out holds a valid byte.
REQ-010 The block SHALL have the port output_enable, input, 1 bit: the reader accepts data_out this cycle.

Function
REQ-011 Storage SHALL be a DEPTH x 16 circular buffer with write pointer wr_ptr, read pointer rd_ptr, word count cnt (0..DEPTH) and byte-select flag half.
REQ-012 input_enable SHALL equal (cnt < DEPTH), derived from registered state only, with no combinational path from output_enable.
REQ-013 A word write SHALL occur on a rising edge when input_valid && input_enable: mem[wr_ptr] <= data_in, and wr_ptr increments modulo DEPTH.
REQ-014 output_valid SHALL equal (cnt > 0).
REQ-015 data_out SHALL be the first byte of mem[rd_ptr] when half = 0, the second byte when half = 1, and 8'h00 whenever output_valid = 0.
REQ-016 A byte read SHALL occur on a rising edge when output_valid && output_enable.
REQ-017 On a byte read with half = 0, the block SHALL set half to 1.
REQ-018 On a byte read with half = 1, the block SHALL clear half to 0, increment rd_ptr modulo DEPTH and pop the word.
REQ-019 cnt SHALL increment on a write only, decrement on a word pop only, and stay unchanged on a simultaneous write and pop.
REQ-020 Latency SHALL be as follows: a word written into an empty buffer at edge N makes output_valid high in the cycle after edge N, with no write-to-read bypass.
REQ-021 When full, input_enable SHALL be 0 even if a pop occurs in the same cycle; the freed slot is offered from the next cycle.
REQ-022 When empty, output_enable SHALL be ignored, and half and rd_ptr SHALL remain unchanged.
REQ-023 Pointer wrap from DEPTH-1 to 0 SHALL be seamless: no lost, duplicated or reordered bytes.
REQ-024 Throughput SHALL be one byte per cycle sustained, which is one word per two cycles; the writer is never stalled when the reader drains continuously.
REQ-025 Byte order on output SHALL follow word arrival order; within a word, order SHALL follow LSB_FIRST.

Reset
REQ-026 While rstn = 0 at a rising edge, the block SHALL set wr_ptr, rd_ptr and cnt to 0 and half to 0, regardless of handshake inputs.
REQ-027 After reset, the outputs SHALL be input_enable = 1, output_valid = 0 and data_out = 8'h00.
REQ-028 A reset mid-word (half = 1) SHALL discard the remaining byte and all buffered words.
REQ-029 Memory contents SHALL NOT be reset.

Structure
REQ-030 The shared package fifo_pkg SHALL hold BYTE_W = 8, WORD_W = 16 and the default DEPTH, shared with the existing packing fifo.
REQ-031 Storage SHALL be in one sub-module, fifo_split_mem: a synchronous-write, asynchronous-read DEPTH x WORD_W register file.
REQ-032 The pointers, cnt, half and handshake logic SHALL reside in fifo_split.

Verification
REQ-033 The bench SHALL cover reset then idle: rstn low for one edge -> input_enable = 1, output_valid = 0, data_out = 8'h00.
REQ-034 The bench SHALL cover a single word: write 16'hA55A with output_enable = 1 -> next cycle data_out = 8'h5A, then 8'hA5, then output_valid = 0.
REQ-035 The bench SHALL cover fill to full: 4 writes (16'h0100..16'h0403) with output_enable = 0 -> input_enable = 0 after the 4th write; a 5th input_valid is ignored.
REQ-036 The bench SHALL cover simultaneous traffic at full: a pop of the second byte with input_valid = 1 in the same cycle -> no write that cycle, input_enable = 1 next cycle, cnt = 3.
REQ-037 The bench SHALL cover wrap-around: 10 words streamed with random input_valid/output_enable (6-ps toggles) -> 20 output bytes in exact LSB-first order.
REQ-038 The bench SHALL cover reset mid-word: after byte 8'h5A of 16'hA55A, rstn low -> output_valid = 0, and 8'hA5 is never emitted.
